uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sampler.sv | 40 ++++
 rtl/uart_rx_core.sv | 137 +++++++++++++
 tb/tb_uart_rx_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, legal oversampling ratios
// and the parity-type encoding also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Anything other than 16 or 32 falls back to 8x oversampling.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter plus 3-sample majority vote around mid-bit.
// bit_done marks the last clock of each bit period.
import uart_pkg::*;

module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] prescale,
  input  logic       rx_bit,
  output logic       bit_done,
  output logic       sampled_bit
);

  logic [5:0] edge_cnt;
  logic [5:0] mid;
  logic [2:0] samples;

  assign mid = prescale >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      samples  <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;
      if (edge_cnt == mid - 6'd1) samples[0] <= rx_bit;
      if (edge_cnt == mid)        samples[1] <= rx_bit;
      if (edge_cnt == mid + 6'd1) samples[2] <= rx_bit;
    end
  end

  assign bit_done    = run && (edge_cnt == prescale - 6'd1);
  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizer, frame FSM, parity/stop checking and the
// registered data/error pulses.
import uart_pkg::*;

module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]            sync_q;
  logic                  rx_sync;
  rx_state_t             state;
  rx_state_t             next_state;
  logic [5:0]            ps_reg;
  logic [5:0]            ps_eff;
  logic                  par_en_reg;
  par_type_t             par_typ_reg;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_pend;
  logic                  run;
  logic                  bit_done;
  logic                  sampled_bit;
  logic                  last_bit;
  logic                  exp_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx_in};
  end

  assign rx_sync = sync_q[1];

  // The detecting IDLE cycle counts as edge 0 of the start bit, so frame
  // timing does not slip by a clock on back-to-back traffic.
  assign run    = (state != IDLE) || !rx_sync;
  assign ps_eff = (state == IDLE) ? legal_prescale(prescale) : ps_reg;

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .prescale    (ps_eff),
    .rx_bit      (rx_sync),
    .bit_done    (bit_done),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_reg      <= PRESCALE_8;
      par_en_reg  <= 1'b0;
      par_typ_reg <= PAR_EVEN;
    end else if (state == IDLE) begin
      ps_reg      <= legal_prescale(prescale);
      par_en_reg  <= par_en;
      par_typ_reg <= par_type_t'(par_typ);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  assign last_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign exp_par  = (^shift_reg) ^ (par_typ_reg == PAR_ODD);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_sync) next_state = START;
      START:   if (bit_done) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_done && last_bit) next_state = par_en_reg ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pulses are registered; p_data loads on the same edge data_valid rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_pend   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          par_pend <= 1'b0;
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BCW'(1);
          end
        end
        PARITY: begin
          if (bit_done) par_pend <= (sampled_bit != exp_par);
        end
        STOP: begin
          if (bit_done) begin
            if (!par_pend && sampled_bit) begin
              data_valid <= 1'b1;
              p_data     <= shift_reg;
            end else begin
              par_err <= par_pend;
              stp_err <= !sampled_bit;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized
// frames scored against a frame-level parity/stop model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int pdata_bad = 0;
  int cycle = 0;
  logic [7:0] prev_pdata = 8'h00;
  logic [7:0] model_pdata = 8'h00;
  int         dv_cycle[$];
  logic [7:0] dv_data[$];

  logic [5:0] r_ps;
  logic [7:0] r_d;
  logic       r_pen, r_ptyp, r_pbit, r_sbit;
  logic [7:0] abort_data;
  int         b_dv, b_pe, b_se;

  uart_rx_core #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        dv_cnt++;
        dv_data.push_back(p_data);
        dv_cycle.push_back(cycle);
      end
      if (par_err) pe_cnt++;
      if (stp_err) se_cnt++;
      if (!data_valid && (p_data != prev_pdata)) pdata_bad++;
    end
    prev_pdata = p_data;
  end

  function automatic int effPs(input logic [5:0] p);
    if (p == 6'd16) return 16;
    if (p == 6'd32) return 32;
    return 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic b, input int cycles);
    rx_in = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] ps_in, input logic [7:0] d,
                               input logic pen, input logic ptyp,
                               input logic pbit, input logic sbit,
                               input int gap, input bit scramble);
    int ps = effPs(ps_in);
    prescale = ps_in;
    par_en   = pen;
    par_typ  = ptyp;
    driveBit(1'b0, ps);
    if (scramble) begin
      prescale = 6'($urandom_range(0, 63));
      par_en   = ~pen;
      par_typ  = ~ptyp;
    end
    for (int i = 0; i < 8; i++) driveBit(d[i], ps);
    if (pen) driveBit(pbit, ps);
    driveBit(sbit, ps);
    prescale = ps_in;
    par_en   = pen;
    par_typ  = ptyp;
    if (gap > 0) driveBit(1'b1, gap);
  endtask

  // Frame-level reference: count ones including the parity bit, even/odd
  // total decides parity, and a low stop bit is a framing error.
  task automatic runFrame(input string tag, input logic [5:0] ps_in,
                          input logic [7:0] d, input logic pen, input logic ptyp,
                          input logic pbit, input logic sbit, input int gap,
                          input bit scramble);
    int s_dv = dv_cnt;
    int s_pe = pe_cnt;
    int s_se = se_cnt;
    int ones;
    int par_bad;
    int edv;
    applyStimulus(ps_in, d, pen, ptyp, pbit, sbit, gap, scramble);
    ones    = $countones(d) + int'(pbit);
    par_bad = (pen && ((ones % 2) != int'(ptyp))) ? 1 : 0;
    edv     = (par_bad == 0 && sbit) ? 1 : 0;
    if (edv == 1) model_pdata = d;
    checkOutput({tag, ".valid"}, dv_cnt - s_dv, edv);
    checkOutput({tag, ".par_err"}, pe_cnt - s_pe, par_bad);
    checkOutput({tag, ".stp_err"}, se_cnt - s_se, sbit ? 0 : 1);
    checkOutput({tag, ".p_data"}, p_data, model_pdata);
  endtask

  initial begin
    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.p_data", p_data, 8'h00);
    checkOutput("reset.data_valid", data_valid, 1'b0);
    checkOutput("reset.par_err", par_err, 1'b0);
    checkOutput("reset.stp_err", stp_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    runFrame("a5_even_p8", 6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    runFrame("3c_oddbad_p16", 6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 32, 1'b0);
    runFrame("5a_stop0_p8", 6'd8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0);

    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    prescale = 6'd16;
    driveBit(1'b0, 3);
    driveBit(1'b1, 64);
    checkOutput("glitch.valid", dv_cnt - b_dv, 0);
    checkOutput("glitch.par_err", pe_cnt - b_pe, 0);
    checkOutput("glitch.stp_err", se_cnt - b_se, 0);
    runFrame("post_glitch", 6'd16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 32, 1'b0);

    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    applyStimulus(6'd32, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    applyStimulus(6'd32, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 64, 1'b0);
    checkOutput("b2b.count", dv_cnt - b_dv, 2);
    checkOutput("b2b.errs", (pe_cnt - b_pe) + (se_cnt - b_se), 0);
    if (dv_data.size() >= 2) begin
      checkOutput("b2b.first", dv_data[dv_data.size()-2], 8'h00);
      checkOutput("b2b.second", dv_data[dv_data.size()-1], 8'hFF);
      checkOutput("b2b.spacing", dv_cycle[dv_cycle.size()-1] - dv_cycle[dv_cycle.size()-2], 320);
    end else begin
      checkOutput("b2b.recorded", dv_data.size(), 2);
    end
    model_pdata = 8'hFF;
    checkOutput("b2b.p_data", p_data, model_pdata);

    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    abort_data = 8'h66;
    prescale = 6'd8;
    par_en   = 1'b0;
    driveBit(1'b0, 8);
    for (int i = 0; i < 4; i++) driveBit(abort_data[i], 8);
    driveBit(abort_data[4], 4);
    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_pdata = 8'h00;
    checkOutput("abort.in_reset.p_data", p_data, model_pdata);
    checkOutput("abort.in_reset.valid", data_valid, 1'b0);
    rst = 1'b1;
    driveBit(1'b1, 20);
    checkOutput("abort.valid", dv_cnt - b_dv, 0);
    checkOutput("abort.errs", (pe_cnt - b_pe) + (se_cnt - b_se), 0);
    runFrame("post_reset_81", 6'd8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       r_ps = 6'd8;
        1:       r_ps = 6'd16;
        2:       r_ps = 6'd32;
        3:       r_ps = 6'd12;
        4:       r_ps = 6'd0;
        default: r_ps = 6'd40;
      endcase
      r_d    = 8'($urandom);
      r_pen  = 1'($urandom_range(0, 1));
      r_ptyp = 1'($urandom_range(0, 1));
      r_pbit = 1'(($countones(r_d) + int'(r_ptyp)) % 2);
      if ($urandom_range(0, 3) == 0) r_pbit = ~r_pbit;
      r_sbit = ($urandom_range(0, 4) != 0);
      runFrame($sformatf("rnd%0d", n), r_ps, r_d, r_pen, r_ptyp, r_pbit, r_sbit,
               2 * effPs(r_ps), 1'b1);
    end

    checkOutput("p_data_hold", pdata_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
